bus0_default_slave: RTL and testbench

//  AXI4 responder on the bus0 interconnect slave side. It terminates every transaction whose address hits no CFG_BUS0_MAP window.

---
 rtl/bus0_default_slave.sv | 155 +++++++++++++++
 tb/tb_bus0_default_slave.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bus0_default_slave.sv
// bus0_default_slave: AXI4 default/miss slave answering every access with RESP_CODE; error log enabled by BUS0_DEFSLV_ERRLOG_EN
module bus0_default_slave #(
    parameter logic [1:0]           RESP_CODE  = 2'h3,
    parameter int                   DATA_BITS  = 64,
    parameter int                   ADDR_BITS  = 48,
    parameter int                   ID_BITS    = 4,
    parameter int                   USER_BITS  = 1,
    parameter logic [DATA_BITS-1:0] RDATA_FILL = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_aw_valid,
    input  logic [ADDR_BITS-1:0]   i_aw_addr,
    input  logic [ID_BITS-1:0]     i_aw_id,
    input  logic [7:0]             i_aw_len,
    input  logic [2:0]             i_aw_size,
    input  logic [1:0]             i_aw_burst,
    input  logic [USER_BITS-1:0]   i_aw_user,
    input  logic                   i_ar_valid,
    input  logic [ADDR_BITS-1:0]   i_ar_addr,
    input  logic [ID_BITS-1:0]     i_ar_id,
    input  logic [7:0]             i_ar_len,
    input  logic [2:0]             i_ar_size,
    input  logic [1:0]             i_ar_burst,
    input  logic [USER_BITS-1:0]   i_ar_user,
    input  logic                   i_w_valid,
    input  logic [DATA_BITS-1:0]   i_w_data,
    input  logic [DATA_BITS/8-1:0] i_w_strb,
    input  logic                   i_w_last,
    input  logic                   i_b_ready,
    input  logic                   i_r_ready,
    output logic                   o_aw_ready,
    output logic                   o_ar_ready,
    output logic                   o_w_ready,
    output logic                   o_b_valid,
    output logic [1:0]             o_b_resp,
    output logic [ID_BITS-1:0]     o_b_id,
    output logic [USER_BITS-1:0]   o_b_user,
    output logic                   o_r_valid,
    output logic [1:0]             o_r_resp,
    output logic [DATA_BITS-1:0]   o_r_data,
    output logic                   o_r_last,
    output logic [ID_BITS-1:0]     o_r_id,
    output logic [USER_BITS-1:0]   o_r_user,
    output logic                   o_err_valid,
    output logic                   o_err_we,
    output logic [ADDR_BITS-1:0]   o_err_addr,
    output logic [15:0]            o_err_cnt
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RDATA = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;
    localparam logic [1:0] WRESP = 2'd3;

    logic [1:0]           r_state;
    logic                 r_last_rd;
    logic [7:0]           r_cnt;
    logic [ID_BITS-1:0]   r_id;
    logic [USER_BITS-1:0] r_user;
    logic                 w_idle;
    logic                 w_ar_hs;
    logic                 w_aw_hs;
    logic                 w_rd;
    logic                 w_wr;
    logic                 w_wresp;
    logic                 w_r_last;
    logic                 w_unused;

    assign w_idle   = r_state == IDLE;
    assign w_rd     = r_state == RDATA;
    assign w_wr     = r_state == WDATA;
    assign w_wresp  = r_state == WRESP;
    assign w_ar_hs  = w_idle & i_ar_valid & (!i_aw_valid | !r_last_rd);
    assign w_aw_hs  = w_idle & i_aw_valid & !w_ar_hs;
    assign w_r_last = r_cnt == 8'd0;
    // burst shape, write payload and (without the log) addresses never influence the response
    assign w_unused = ^{i_aw_len, i_aw_size, i_aw_burst, i_ar_size, i_ar_burst, i_w_data, i_w_strb, i_aw_addr, i_ar_addr};

    assign o_ar_ready = w_ar_hs;
    assign o_aw_ready = w_aw_hs;
    assign o_w_ready  = w_wr;
    assign o_r_valid  = w_rd;
    assign o_r_last   = w_rd & w_r_last;
    assign o_r_resp   = w_rd ? RESP_CODE : 2'd0;
    assign o_r_data   = w_rd ? RDATA_FILL : '0;
    assign o_r_id     = r_id;
    assign o_r_user   = r_user;
    assign o_b_valid  = w_wresp;
    assign o_b_resp   = w_wresp ? RESP_CODE : 2'd0;
    assign o_b_id     = r_id;
    assign o_b_user   = r_user;

    // one transaction at a time: accept AR/AW in IDLE, stream read beats or sink write beats, then respond
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_last_rd <= 1'b0;
            r_cnt     <= 8'd0;
            r_id      <= '0;
            r_user    <= '0;
        end else if (w_ar_hs) begin
            r_state   <= RDATA;
            r_cnt     <= i_ar_len;
            r_last_rd <= 1'b1;
            r_id      <= i_ar_id;
            r_user    <= i_ar_user;
        end else if (w_aw_hs) begin
            r_state   <= WDATA;
            r_last_rd <= 1'b0;
            r_id      <= i_aw_id;
            r_user    <= i_aw_user;
        end else if (w_rd && i_r_ready) begin
            r_cnt   <= r_cnt - 8'd1;
            r_state <= w_r_last ? IDLE : RDATA;
        end else if (w_wr && i_w_valid && i_w_last) begin
            r_state <= WRESP;
        end else if (w_wresp && i_b_ready) begin
            r_state <= IDLE;
        end
    end

`ifdef BUS0_DEFSLV_ERRLOG_EN
    logic                 r_err_valid;
    logic                 r_err_we;
    logic [ADDR_BITS-1:0] r_err_addr;
    logic [15:0]          r_err_cnt;

    assign o_err_valid = r_err_valid;
    assign o_err_we    = r_err_we;
    assign o_err_addr  = r_err_addr;
    assign o_err_cnt   = r_err_cnt;

    // record every accepted access; the count sticks at all-ones instead of wrapping
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_valid <= 1'b0;
            r_err_we    <= 1'b0;
            r_err_addr  <= '0;
            r_err_cnt   <= 16'd0;
        end else begin
            r_err_valid <= w_ar_hs | w_aw_hs;
            if (w_ar_hs | w_aw_hs) begin
                r_err_we   <= w_aw_hs;
                r_err_addr <= w_aw_hs ? i_aw_addr : i_ar_addr;
                r_err_cnt  <= (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;
            end
        end
    end
`else
    assign o_err_valid = 1'b0;
    assign o_err_we    = 1'b0;
    assign o_err_addr  = '0;
    assign o_err_cnt   = 16'd0;
`endif
endmodule

// File: tb/tb_bus0_default_slave.sv
// tb_bus0_default_slave: directed checks of the bus0 default slave
module tb_bus0_default_slave;
`ifdef BUS0_DEFSLV_ERRLOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif
    logic        clk = 0;
    logic        rst = 1;
    logic        aw_valid = 0, ar_valid = 0, w_valid = 0, w_last = 0, b_ready = 0, r_ready = 0;
    logic [47:0] aw_addr = 0, ar_addr = 0;
    logic [3:0]  aw_id = 0, ar_id = 0;
    logic [7:0]  aw_len = 0, ar_len = 0;
    logic [0:0]  aw_user = 0, ar_user = 0;
    logic [63:0] w_data = 0;
    logic [7:0]  w_strb = 0;
    logic        aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last, err_valid, err_we;
    logic [1:0]  b_resp, r_resp;
    logic [3:0]  b_id, r_id;
    logic [0:0]  b_user, r_user;
    logic [63:0] r_data;
    logic [47:0] err_addr;
    logic [15:0] err_cnt;
    int checks = 0, failures = 0, pulses = 0;

    bus0_default_slave dut (
        .i_clk(clk), .i_rst(rst),
        .i_aw_valid(aw_valid), .i_aw_addr(aw_addr), .i_aw_id(aw_id), .i_aw_len(aw_len),
        .i_aw_size(3'd3), .i_aw_burst(2'd1), .i_aw_user(aw_user),
        .i_ar_valid(ar_valid), .i_ar_addr(ar_addr), .i_ar_id(ar_id), .i_ar_len(ar_len),
        .i_ar_size(3'd3), .i_ar_burst(2'd1), .i_ar_user(ar_user),
        .i_w_valid(w_valid), .i_w_data(w_data), .i_w_strb(w_strb), .i_w_last(w_last),
        .i_b_ready(b_ready), .i_r_ready(r_ready),
        .o_aw_ready(aw_ready), .o_ar_ready(ar_ready), .o_w_ready(w_ready),
        .o_b_valid(b_valid), .o_b_resp(b_resp), .o_b_id(b_id), .o_b_user(b_user),
        .o_r_valid(r_valid), .o_r_resp(r_resp), .o_r_data(r_data), .o_r_last(r_last),
        .o_r_id(r_id), .o_r_user(r_user),
        .o_err_valid(err_valid), .o_err_we(err_we), .o_err_addr(err_addr), .o_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (err_valid) pulses++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs, lasts, stall_bad, last_ok, done;
        logic rr, stalled;
        logic [71:0] prev;
        #1;
        chk("rst_r_valid", r_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_r_fields", {r_resp, r_id, r_user, r_data, r_last}, 0);
        chk("rst_b_fields", {b_resp, b_id, b_user}, 0);
        chk("rst_err", {err_valid, err_we, err_addr, err_cnt}, 0);
        cyc; cyc;
        rst = 0;
        cyc;
        // 1: single-beat read
        ar_valid = 1; ar_len = 0; ar_id = 5; #1;
        chk("t1_ar_ready", ar_ready, 1);
        chk("t1_aw_ready", aw_ready, 0);
        cyc;
        ar_valid = 0; #1;
        chk("t1_r", {r_valid, r_last, r_resp, r_id, r_data}, {1'b1, 1'b1, 2'h3, 4'd5, 64'h0});
        chk("t1_ar_ready_busy", dut.o_ar_ready, 0);
        r_ready = 1;
        cyc;
        r_ready = 0;
        chk("t1_idle_r_valid", r_valid, 0);
        ar_valid = 1; #1;
        chk("t1_ar_ready_again", ar_ready, 1);
        ar_valid = 0; #1;
        // 2: 256-beat read with stalled r_ready
        ar_valid = 1; ar_len = 255; ar_id = 9; ar_user = 1;
        cyc;
        ar_valid = 0;
        hs = 0; lasts = 0; stall_bad = 0; last_ok = 0; done = 0; rr = 1; stalled = 0; prev = 0;
        for (int k = 0; k < 1200 && done == 0; k++) begin
            r_ready = rr; #1;
            if (r_valid) begin
                if (stalled && {r_last, r_id, r_user, r_resp, r_data} !== prev) stall_bad++;
                if (rr) begin
                    hs++;
                    if (r_last) lasts++;
                    if (hs == 256) begin
                        last_ok = r_last ? 1 : 0;
                        done = 1;
                    end
                end
            end
            prev = {r_last, r_id, r_user, r_resp, r_data};
            stalled = r_valid & !rr;
            cyc;
            rr = !rr;
        end
        r_ready = 0; #1;
        chk("t2_handshakes", hs, 256);
        chk("t2_last_count", lasts, 1);
        chk("t2_last_on_256", last_ok, 1);
        chk("t2_stall_stable", stall_bad, 0);
        chk("t2_done_idle", r_valid, 0);
        // 3: write burst, delayed b_ready
        aw_valid = 1; aw_id = 3; aw_len = 3; w_valid = 1; #1;
        chk("t3_aw_ready", aw_ready, 1);
        chk("t3_no_w_in_idle", w_ready, 0);
        cyc;
        aw_valid = 0; #1;
        chk("t3_w_ready", w_ready, 1);
        for (int i = 0; i < 4; i++) begin
            w_valid = 1; w_last = (i == 3); w_data = 64'(i);
            cyc;
        end
        w_valid = 0; w_last = 0; #1;
        chk("t3_b", {b_valid, b_resp, b_id}, {1'b1, 2'h3, 4'd3});
        chk("t3_w_ready_off", w_ready, 0);
        for (int i = 0; i < 5; i++) begin
            cyc;
            chk("t3_b_hold", {b_valid, b_resp, b_id}, {1'b1, 2'h3, 4'd3});
        end
        b_ready = 1;
        cyc;
        b_ready = 0; #1;
        chk("t3_b_done", b_valid, 0);
        // 4: simultaneous AW+AR alternation from reset
        rst = 1; cyc; rst = 0; cyc;
        aw_valid = 1; ar_valid = 1; aw_id = 2; ar_id = 1; aw_len = 0; ar_len = 0;
        w_valid = 1; w_last = 1; #1;
        chk("t4_first_read", {ar_ready, aw_ready, w_ready}, 3'b100);
        cyc;
        ar_valid = 0; #1;
        chk("t4_r", {r_valid, r_id, w_ready, aw_ready}, {1'b1, 4'd1, 1'b0, 1'b0});
        r_ready = 1;
        cyc;
        r_ready = 0; ar_valid = 1; #1;
        chk("t4_then_write", {ar_ready, aw_ready, w_ready}, 3'b010);
        cyc;
        aw_valid = 0; #1;
        chk("t4_wdata", {w_ready, ar_ready}, 2'b10);
        cyc;
        w_valid = 0; w_last = 0; #1;
        chk("t4_b", {b_valid, b_id}, {1'b1, 4'd2});
        b_ready = 1;
        cyc;
        b_ready = 0; aw_valid = 1; #1;
        chk("t4_then_read", {ar_ready, aw_ready}, 2'b10);
        aw_valid = 0; ar_valid = 0; #1;
        // 5: async reset mid-burst
        ar_valid = 1; ar_len = 7; ar_id = 4; r_ready = 1;
        cyc;
        ar_valid = 0;
        cyc; cyc;
        chk("t5_beat2", {r_valid, r_last}, 2'b10);
        rst = 1; #1;
        chk("t5_async_drop", r_valid, 0);
        cyc;
        rst = 0;
        cyc;
        chk("t5_no_resume", r_valid, 0);
        ar_valid = 1; ar_len = 0; ar_id = 6; #1;
        chk("t5_ar_ready", ar_ready, 1);
        cyc;
        ar_valid = 0; #1;
        chk("t5_r", {r_valid, r_last, r_resp, r_id}, {1'b1, 1'b1, 2'h3, 4'd6});
        cyc;
        chk("t5_idle", r_valid, 0);
        r_ready = 0;
        // 6: error log
        rst = 1; cyc; rst = 0; cyc;
        pulses = 0;
        ar_valid = 1; ar_addr = 48'h1000; ar_len = 0;
        cyc;
        ar_valid = 0; #1;
        chk("t6_log_rd", {err_valid, err_we, err_addr}, LOG ? {1'b1, 1'b0, 48'h1000} : 50'h0);
        r_ready = 1; cyc; r_ready = 0;
        chk("t6_pulse_1cyc", err_valid, 0);
        aw_valid = 1; aw_addr = 48'h3000_0000;
        cyc;
        aw_valid = 0; w_valid = 1; w_last = 1;
        cyc;
        w_valid = 0; w_last = 0; b_ready = 1;
        cyc;
        b_ready = 0;
        aw_valid = 1; aw_addr = 48'h2000_0000;
        cyc;
        aw_valid = 0; w_valid = 1; w_last = 1;
        cyc;
        w_valid = 0; w_last = 0; b_ready = 1;
        cyc;
        b_ready = 0; #1;
        chk("t6_cnt", err_cnt, LOG ? 3 : 0);
        chk("t6_addr", err_addr, LOG ? 48'h2000_0000 : 0);
        chk("t6_we", err_we, LOG ? 1 : 0);
        chk("t6_pulses", pulses, LOG ? 3 : 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
